// File: rtl/cs_rr_scheduler.sv
// Round-robin scheduler driving a shared 74138-style decoder: SETUP, ACTIVE, RECOVER per grant.
// Outputs registered; select valid 1 cycle after request sampled, grant/enables 2 cycles after; no backpressure.
module cs_rr_scheduler #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] req_i,
  input  logic       done_i,
  output logic       select_a_o,
  output logic       select_b_o,
  output logic       select_c_o,
  output logic       g1_en_o,
  output logic       g2a_en_n_o,
  output logic       g2b_en_n_o,
  output logic [7:0] grant_o,
  output logic       busy_o,
  output logic       timeout_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    ACTIVE  = 2'd2,
    RECOVER = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ptr_q, ptr_d;
  logic [2:0]    sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [2:0]    select_q, select_d;
  logic          en_q, en_d;
  logic [7:0]    grant_q, grant_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          win_vld;
  logic [2:0]    win_idx;

  // Scan from the top offset down so the lowest offset from ptr is the last to stick.
  always_comb begin
    win_vld = 1'b0;
    win_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (req_i[ptr_q + 3'(i)]) begin
        win_vld = 1'b1;
        win_idx = ptr_q + 3'(i);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      ptr_q     <= 3'd0;
      sel_q     <= 3'd0;
      cnt_q     <= '0;
      select_q  <= 3'd0;
      en_q      <= 1'b0;
      grant_q   <= 8'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      select_q  <= select_d;
      en_q      <= en_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RECOVER: begin
        if (win_vld) begin
          state_d = SETUP;
          sel_d   = win_idx;
          ptr_d   = win_idx + 3'd1;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
      ACTIVE: begin
        cnt_d = cnt_q + CW'(1);
        if (done_i || (cnt_q == CNT_LAST)) begin
          state_d = RECOVER;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so they line up with the state register.
  always_comb begin
    select_d  = sel_d;
    en_d      = (state_d == ACTIVE);
    grant_d   = (state_d == ACTIVE) ? (8'd1 << sel_d) : 8'd0;
    busy_d    = (state_d != IDLE);
    timeout_d = (state_q == ACTIVE) && !done_i && (cnt_q == CNT_LAST);
  end

  assign select_a_o = select_q[0];
  assign select_b_o = select_q[1];
  assign select_c_o = select_q[2];
  assign g1_en_o    = en_q;
  assign g2a_en_n_o = ~en_q;
  assign g2b_en_n_o = ~en_q;
  assign grant_o    = grant_q;
  assign busy_o     = busy_q;
  assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_cs_rr_scheduler.sv
// Bench for cs_rr_scheduler: transaction-level model compared every cycle, plus directed literal checks.
module tb_cs_rr_scheduler;
  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic       sa, sb, sc, g1, g2a_n, g2b_n, busy, tmo;
  logic [7:0] grant;

  cs_rr_scheduler #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .select_a_o(sa), .select_b_o(sb), .select_c_o(sc),
    .g1_en_o(g1), .g2a_en_n_o(g2a_n), .g2b_en_n_o(g2b_n),
    .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sel_now();
    return {29'd0, sc, sb, sa};
  endfunction

  // Transaction model: phase 0 idle, 1 setup, 2 active, 3 recover; age counts ACTIVE cycles so far.
  int m_phase = 0, m_ptr = 0, m_sel = 0, m_age = 0;
  bit m_tmo = 1'b0;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_sel = 0; m_age = 0; m_tmo = 1'b0;
    end else begin
      case (m_phase)
        0, 3: begin
          m_tmo = 1'b0;
          if (req != 8'd0) begin
            m_sel = pick(req, m_ptr);
            m_ptr = (m_sel + 1) % 8;
            m_phase = 1;
          end else m_phase = 0;
        end
        1: begin m_phase = 2; m_age = 1; end
        default: begin
          if (done) begin m_phase = 3; m_tmo = 1'b0; end
          else if (m_age == T) begin m_phase = 3; m_tmo = 1'b1; end
          else m_age++;
        end
      endcase
    end
  end

  logic [2:0] prev_sel;
  logic       prev_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, (m_phase != 0));
      chk("sel", sel_now(), m_sel);
      chk("g1_en", g1, (m_phase == 2));
      chk("g2a_en_n", g2a_n, (m_phase != 2));
      chk("g2b_en_n", g2b_n, (m_phase != 2));
      chk("grant", grant, (m_phase == 2) ? (32'd1 << m_sel) : 32'd0);
      chk("timeout", tmo, m_tmo);
      chk("grant_onehot", ($countones(grant) <= 1), 1);
      if (prev_en && g1) chk("sel_stable_when_enabled", {sa, sb, sc} == {prev_sel[0], prev_sel[1], prev_sel[2]}, 1);
      prev_en  = g1;
      prev_sel = {sc, sb, sa};
    end
  end

  int         act_cnt, to_cnt, to_at, idle_cnt, n_g;
  int         g_order[$];
  int         g_cycle[$];

  initial begin
    // Reset with random requests
    repeat (4) begin
      @(negedge clk);
      chk_en = 1'b1;
      req = 8'($urandom);
      chk("rst_busy", busy, 0);
      chk("rst_g2a", g2a_n, 1);
      chk("rst_g2b", g2b_n, 1);
      chk("rst_grant", grant, 0);
    end
    @(negedge clk); rst = 1'b0; req = 8'd0;

    // Single transaction on requester 3, done on 3rd ACTIVE cycle
    @(negedge clk); req = 8'h08;
    @(negedge clk); req = 8'h00;
    chk("single_setup_sel", sel_now(), 3);
    chk("single_setup_busy", busy, 1);
    chk("single_setup_g1", g1, 0);
    @(negedge clk); chk("single_a1", grant, 8'h08);
    @(negedge clk); chk("single_a2", grant, 8'h08);
    @(negedge clk); chk("single_a3", grant, 8'h08); done = 1'b1;
    @(negedge clk); done = 1'b0;
    chk("single_rec_grant", grant, 0);
    chk("single_rec_busy", busy, 1);
    chk("single_rec_sel", sel_now(), 3);
    @(negedge clk); chk("single_idle_busy", busy, 0);
    // ptr should now be 4, so 4 beats 3
    req = 8'h18;
    @(negedge clk); req = 8'h00; chk("ptr4_sel", sel_now(), 4);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    @(negedge clk);

    // Rotation with all requesting and done every ACTIVE cycle
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 8'hFF; done = 1'b1;
    idle_cnt = 0;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk);
      if (!busy) idle_cnt++;
      if (grant != 8'd0) begin
        g_order.push_back(int'(sel_now()));
        g_cycle.push_back(c);
      end
    end
    chk("rot_idle_cycles", idle_cnt, 0);
    chk("rot_grant_count_ge9", (g_order.size() >= 9), 1);
    n_g = (g_order.size() < 9) ? g_order.size() : 9;
    for (int i = 0; i < n_g; i++) chk("rot_order", g_order[i], i % 8);
    for (int i = 1; i < n_g; i++) chk("rot_period", g_cycle[i] - g_cycle[i-1], 3);
    req = 8'h00;
    repeat (4) @(negedge clk);
    done = 1'b0;
    @(negedge clk);

    // Pointer priority: grant 5, then 8'h21 must go to 0
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; req = 8'h20;
    @(negedge clk); req = 8'h00; chk("prio_first_sel", sel_now(), 5);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    @(negedge clk); req = 8'h21;
    @(negedge clk); req = 8'h00; chk("prio_wrap_sel", sel_now(), 0);
    @(negedge clk); done = 1'b1;
    @(negedge clk); done = 1'b0;
    @(negedge clk);

    // Timeout with done held low
    req = 8'h04;
    @(negedge clk); req = 8'h00;
    act_cnt = 0; to_cnt = 0; to_at = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      act_cnt += int'(g1);
      if (tmo) begin to_cnt++; to_at = i; end
    end
    chk("tmo_active_len", act_cnt, T);
    chk("tmo_pulse_count", to_cnt, 1);
    chk("tmo_pulse_pos", to_at, T);

    // done on the timeout cycle counts as done
    req = 8'h04;
    @(negedge clk); req = 8'h00;
    act_cnt = 0; to_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      act_cnt += int'(g1);
      if (tmo) to_cnt++;
      done = (i == T - 1);
    end
    done = 1'b0;
    chk("tmo_done_active_len", act_cnt, T);
    chk("tmo_done_no_pulse", to_cnt, 0);

    // Reset on 2nd ACTIVE cycle
    req = 8'h01;
    @(negedge clk); req = 8'h00;
    @(negedge clk);
    @(negedge clk); chk("midrst_a2_grant", grant, 8'h01); rst = 1'b1;
    @(negedge clk);
    chk("midrst_g1", g1, 0);
    chk("midrst_g2a", g2a_n, 1);
    chk("midrst_g2b", g2b_n, 1);
    chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0);
    rst = 1'b0;

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req  = 8'($urandom) & 8'($urandom);
      done = ($urandom_range(0, 2) == 0);
      rst  = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0; req = 8'h00; done = 1'b0;
    repeat (8) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cs_rr_scheduler.md
# cs_rr_scheduler

Round-robin chip-select scheduler that shares one 3-to-8 active-low decoder (74138-style) among eight requesters. It arbitrates pending requests and drives the decoder's select and enable inputs through a setup / active / recover sequence for each transaction. It closes each transaction on a requester done strobe or a timeout. It sits directly in front of the decoder; the decoder's yn outputs form the board-level chip selects.

## Interface
- TIMEOUT_CYCLES, default 255: maximum ACTIVE cycles per transaction, legal range 1..65535.
- clk_i input 1: single clock, all logic on rising edge.
- rst_i input 1: synchronous, active-high reset.
- req_i input 8: per-requester request, level-sensitive; bit n is requester n.
- done_i input 1: the granted requester ends its transaction; sampled only in ACTIVE.
- select_a_o output 1: decoder select bit 0 (LSB of the granted index).
- select_b_o output 1: decoder select bit 1.
- select_c_o output 1: decoder select bit 2 (MSB).
- g1_en_o output 1: decoder enable, active-high.
- g2a_en_n_o output 1: decoder enable, active-low.
- g2b_en_n_o output 1: decoder enable, active-low.
- grant_o output 8: one-hot grant, high only in ACTIVE.
- busy_o output 1: high in SETUP, ACTIVE and RECOVER.
- timeout_o output 1: one-cycle pulse when a transaction is ended by timeout.

## Operation
- All outputs are registered.
- **States:** IDLE, SETUP, ACTIVE, RECOVER. The state is held in a 2-bit register.
- **Arbitration:**
  - Arbitration runs in IDLE and in RECOVER.
  - The winner is the first set bit of req_i scanning ptr, ptr+1, … ptr+7, all modulo 8.
  - ptr is a 3-bit rotating priority pointer.
  - On every grant, ptr is set to winner+1 mod 8, so 7 wraps to 0.
- **IDLE:**
  - If req_i is nonzero, latch the winner index into sel[2:0] and go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP (exactly 1 cycle):**
  - select_*_o drive sel; enables are inactive.
  - Then go to ACTIVE, clearing the timeout counter.
- **ACTIVE:**
  - Enables are asserted: g1_en_o=1, g2a_en_n_o=0, g2b_en_n_o=0.
  - grant_o[sel]=1, and sel is held stable.
  - The counter increments each ACTIVE cycle. Its width is clog2(TIMEOUT_CYCLES+1).
  - If done_i=1, go to RECOVER.
  - Else if counter == TIMEOUT_CYCLES-1, go to RECOVER and set timeout_o for the next cycle.
  - done_i and timeout on the same cycle count as done: no timeout pulse.
- **RECOVER (exactly 1 cycle):**
  - Enables are inactive, grant_o=0, select_*_o still hold the old sel.
  - Arbitrate: if any request is pending, latch the new winner and go straight to SETUP; else go to IDLE.
- **Request handling:**
  - Deassertion of req_i after the grant is ignored. The transaction ends only by done_i or timeout.
  - done_i outside ACTIVE is ignored.
  - The granted requester's own req bit is eligible again at the next arbitration. It has the lowest priority there because ptr has moved past it.
- **Enable invariant:** the decoder is never enabled while the select lines change.
  - select_*_o may change only on cycles where the enables are inactive (IDLE→SETUP or RECOVER→SETUP edge).
- **Reset values:**
  - state=IDLE, ptr=0, sel=0.
  - select_a/b/c_o=0, g1_en_o=0, g2a_en_n_o=1, g2b_en_n_o=1.
  - grant_o=0, busy_o=0, timeout_o=0, counter=0.
- **Reset mid-transaction:** reset asserted in any state returns to the reset values on the next edge. Enables deassert immediately at that edge; no RECOVER cycle is inserted.

## Timing
- **Grant latency:** req_i is sampled high at IDLE edge N. Then busy_o=1 and sel is valid at N+1 (SETUP), and enables plus grant_o are valid at N+2.
- **ACTIVE length:** from 1 cycle (done_i high on the first ACTIVE cycle) up to TIMEOUT_CYCLES cycles.
- **Back-to-back transactions:** the per-transaction cycle pattern is SETUP, ACTIVE×k, RECOVER, then SETUP again. There is no IDLE cycle between transactions, so the overhead is 2 cycles per transaction.
- **timeout_o:** high exactly during the RECOVER cycle that follows the final ACTIVE cycle.
- **Decoder outputs:** when enabled, exactly one decoder output is low. The decoder is combinational, so yn[sel] goes low in the same cycle as grant_o.

## Test plan
- **Reset defaults:** drive reset with random req_i → all outputs at reset values; g2a_en_n_o=g2b_en_n_o=1; busy_o=0 for the whole reset.
- **Single transaction:** req_i=8'h08 at IDLE, done_i pulsed on the 3rd ACTIVE cycle → sel=3 at N+1; grant_o=8'h08 for 3 cycles; RECOVER; IDLE; ptr=4.
- **Round-robin rotation:** req_i=8'hFF held, done_i=1 on every ACTIVE cycle → grant order 0,1,…,7,0 (wraps); period 3 cycles; no IDLE cycles.
- **Pointer priority:** ptr=6 (after granting 5), req_i=8'h21 → requester 0 wins before 5.
- **Timeout:** TIMEOUT_CYCLES=4, done_i held low → ACTIVE for exactly 4 cycles, then timeout_o=1 for 1 cycle. A second run with done_i and timeout on the same cycle → no timeout_o pulse.
- **Mid-transaction reset and invariant:** rst_i asserted on the 2nd ACTIVE cycle → enables inactive at the next edge. With random req/done stimulus, a checker confirms select_*_o never change while g1_en_o=1, and at most one grant_o bit is high at any time.
